midi_rx: RTL and testbench

MIDI input stage for the MiniMoog synth: receives the 31250-baud MIDI serial stream and decodes it into the monophonic note and pitch-bend controls that the oscillator bank consumes. It sits directly upstream of the oscillator bank, replacing its constant note (69) and bend (0x2000) inputs. It also provides a gate and velocity for the future envelope stage.

---
 rtl/midi_pkg.sv | 27 ++
 rtl/midi_rx_uart_rx.sv | 96 +++++++++
 rtl/midi_rx.sv | 138 +++++++++++++
 tb/tb_midi_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared constants and state encodings for the MIDI input stage.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] PITCH_BEND = 4'hE;

  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam logic [7:0] SYSTEM_MIN   = 8'hF0;

  localparam logic [6:0]  NOTE_RST    = 7'd69;
  localparam logic [13:0] BEND_CENTRE = 14'h2000;

  typedef enum logic [1:0] {
    UartIdle,
    UartStart,
    UartData,
    UartStop
  } uart_state_e;

  typedef enum logic [1:0] {
    ParseWaitStatus,
    ParseWaitD1,
    ParseWaitD2
  } parse_state_e;

endpackage

// File: rtl/midi_rx_uart_rx.sv
// 8N1 UART receiver with input synchroniser; one registered byte_valid or frame_err
// pulse per frame.
module uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned DIV = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       midi_in,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntFull = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(DIV / 2 - 1);

  // [1:0] is the synchroniser, [2] holds the previous synchronised value for edge detect
  logic [2:0]      sync_q;
  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx, fall;

  assign rx   = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 3'b111;
      state_q <= UartIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], midi_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      UartIdle: begin
        cnt_d = '0;
        if (fall) state_d = UartStart;
      end
      UartStart: begin
        // Mid-start-bit check rejects short low glitches
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? UartIdle : UartData;
        end
      end
      UartData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = UartStop;
        end
      end
      UartStop: begin
        if (cnt_q == CntFull) begin
          state_d = UartIdle;
          valid_d = rx;
          ferr_d  = ~rx;
        end
      end
      default: state_d = UartIdle;
    endcase
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/midi_rx.sv
// MIDI input stage: decodes Note On/Off and pitch bend on one channel into
// monophonic note, bend, velocity and gate controls.
module midi_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 32000000,
  parameter int unsigned BAUD    = 31250,
  parameter logic [3:0]  CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        midi_in,
  output logic [6:0]  note,
  output logic [13:0] bend,
  output logic [6:0]  velocity,
  output logic        gate,
  output logic        note_strobe,
  output logic        frame_err
);

  localparam int unsigned DIV = CLK_HZ / BAUD;

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_rx #(
    .DIV(DIV)
  ) u_uart_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .midi_in   (midi_in),
    .rx_byte   (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (frame_err)
  );

  parse_state_e pstate_q, pstate_d;
  logic [3:0]   status_q, status_d;
  logic         rs_valid_q, rs_valid_d;
  logic [6:0]   d1_q, d1_d;
  logic [6:0]   note_q, note_d;
  logic [13:0]  bend_q, bend_d;
  logic [6:0]   vel_q, vel_d;
  logic         gate_q, gate_d;
  logic         strobe_q, strobe_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pstate_q   <= ParseWaitStatus;
      status_q   <= '0;
      rs_valid_q <= 1'b0;
      d1_q       <= '0;
      note_q     <= NOTE_RST;
      bend_q     <= BEND_CENTRE;
      vel_q      <= '0;
      gate_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      pstate_q   <= pstate_d;
      status_q   <= status_d;
      rs_valid_q <= rs_valid_d;
      d1_q       <= d1_d;
      note_q     <= note_d;
      bend_q     <= bend_d;
      vel_q      <= vel_d;
      gate_q     <= gate_d;
      strobe_q   <= strobe_d;
    end
  end

  always_comb begin
    pstate_d   = pstate_q;
    status_d   = status_q;
    rs_valid_d = rs_valid_q;
    d1_d       = d1_q;
    note_d     = note_q;
    bend_d     = bend_q;
    vel_d      = vel_q;
    gate_d     = gate_q;
    strobe_d   = 1'b0;
    // Realtime bytes fall through untouched
    if (rx_valid && rx_byte < REALTIME_MIN) begin
      if (rx_byte >= SYSTEM_MIN) begin
        rs_valid_d = 1'b0;
        pstate_d   = ParseWaitStatus;
      end else if (rx_byte[7]) begin
        if ((rx_byte[7:4] == NOTE_OFF || rx_byte[7:4] == NOTE_ON ||
             rx_byte[7:4] == PITCH_BEND) && rx_byte[3:0] == CHANNEL) begin
          status_d   = rx_byte[7:4];
          rs_valid_d = 1'b1;
          pstate_d   = ParseWaitD1;
        end else begin
          rs_valid_d = 1'b0;
          pstate_d   = ParseWaitStatus;
        end
      end else begin
        unique case (pstate_q)
          ParseWaitStatus: begin
            if (rs_valid_q) begin
              d1_d     = rx_byte[6:0];
              pstate_d = ParseWaitD2;
            end
          end
          ParseWaitD1: begin
            d1_d     = rx_byte[6:0];
            pstate_d = ParseWaitD2;
          end
          ParseWaitD2: begin
            pstate_d = ParseWaitD1;
            case (status_q)
              NOTE_ON: begin
                if (rx_byte[6:0] != 7'd0) begin
                  note_d   = d1_q;
                  vel_d    = rx_byte[6:0];
                  gate_d   = 1'b1;
                  strobe_d = 1'b1;
                end else if (d1_q == note_q) begin
                  gate_d = 1'b0;
                end
              end
              NOTE_OFF:   if (d1_q == note_q) gate_d = 1'b0;
              PITCH_BEND: bend_d = {rx_byte[6:0], d1_q};
              default:    ;
            endcase
          end
          default: pstate_d = ParseWaitStatus;
        endcase
      end
    end
  end

  assign note        = note_q;
  assign bend        = bend_q;
  assign velocity    = vel_q;
  assign gate        = gate_q;
  assign note_strobe = strobe_q;

endmodule

// File: tb/tb_midi_rx.sv
// Directed bench for midi_rx, run at a reduced clock so one bit is 64 clocks.
module tb_midi_rx;

  localparam int unsigned CLK_HZ = 2000000;
  localparam int unsigned BAUD   = 31250;
  localparam int unsigned DIV    = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        midi_in = 1'b1;
  logic [6:0]  note;
  logic [13:0] bend;
  logic [6:0]  velocity;
  logic        gate;
  logic        note_strobe;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int ferr_cnt = 0;
  int valid_cnt = 0;

  midi_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .CHANNEL(4'd0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .midi_in    (midi_in),
    .note       (note),
    .bend       (bend),
    .velocity   (velocity),
    .gate       (gate),
    .note_strobe(note_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (note_strobe) strobe_cnt++;
    if (frame_err) ferr_cnt++;
    if (dut.rx_valid) valid_cnt++;
  end

  task automatic send_bit(input logic b);
    midi_in = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    midi_in = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    int s0;
    repeat (4) @(negedge clk);
    checks++; if (note !== 7'd69) begin errors++; $display("FAIL reset_note: got %h want %h", note, 7'd69); end
    checks++; if (bend !== 14'h2000) begin errors++; $display("FAIL reset_bend: got %h want %h", bend, 14'h2000); end
    checks++; if (gate !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b want 0", gate); end
    checks++; if (velocity !== 7'd0) begin errors++; $display("FAIL reset_vel: got %h want 0", velocity); end
    reset_n = 1'b1;
    repeat (DIV) @(negedge clk);
    send_byte(8'h90); send_byte(8'h55); send_byte(8'h22);
    send_byte(8'hE0); send_byte(8'h11); send_byte(8'h22);
    settle();
    checks++; if (note !== 7'h55) begin errors++; $display("FAIL pre_note: got %h want %h", note, 7'h55); end
    checks++; if (bend !== 14'h1111) begin errors++; $display("FAIL pre_bend: got %h want %h", bend, 14'h1111); end
    // Reset partway through a frame
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    reset_n = 1'b0;
    midi_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (note !== 7'd69) begin errors++; $display("FAIL midreset_note: got %h want %h", note, 7'd69); end
    checks++; if (bend !== 14'h2000) begin errors++; $display("FAIL midreset_bend: got %h want %h", bend, 14'h2000); end
    checks++; if (gate !== 1'b0) begin errors++; $display("FAIL midreset_gate: got %b want 0", gate); end
    checks++; if (velocity !== 7'd0) begin errors++; $display("FAIL midreset_vel: got %h want 0", velocity); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    s0 = strobe_cnt;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    settle();
    checks++; if (note !== 7'h3C) begin errors++; $display("FAIL post_note: got %h want %h", note, 7'h3C); end
    checks++; if (velocity !== 7'h64) begin errors++; $display("FAIL post_vel: got %h want %h", velocity, 7'h64); end
    checks++; if (gate !== 1'b1) begin errors++; $display("FAIL post_gate: got %b want 1", gate); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL post_strobes: got %0d want 1", strobe_cnt - s0); end
  endtask

  task automatic test_running_status();
    int s0;
    s0 = strobe_cnt;
    send_byte(8'h90); send_byte(8'h40); send_byte(8'h50); send_byte(8'h43); send_byte(8'h50);
    settle();
    checks++; if (strobe_cnt - s0 !== 2) begin errors++; $display("FAIL rs_strobes: got %0d want 2", strobe_cnt - s0); end
    checks++; if (note !== 7'h43) begin errors++; $display("FAIL rs_note: got %h want %h", note, 7'h43); end
    send_byte(8'h40); send_byte(8'h00);
    settle();
    checks++; if (gate !== 1'b1) begin errors++; $display("FAIL rs_other_off_gate: got %b want 1", gate); end
    checks++; if (note !== 7'h43) begin errors++; $display("FAIL rs_other_off_note: got %h want %h", note, 7'h43); end
    send_byte(8'h43); send_byte(8'h00);
    settle();
    checks++; if (gate !== 1'b0) begin errors++; $display("FAIL rs_off_gate: got %b want 0", gate); end
    checks++; if (velocity !== 7'h50) begin errors++; $display("FAIL rs_off_vel: got %h want %h", velocity, 7'h50); end
  endtask

  task automatic test_pitch_bend();
    send_byte(8'hE0); send_byte(8'h7F); send_byte(8'h7F);
    settle();
    checks++; if (bend !== 14'h3FFF) begin errors++; $display("FAIL bend_max: got %h want %h", bend, 14'h3FFF); end
    send_byte(8'hE0); send_byte(8'h00); send_byte(8'h00);
    settle();
    checks++; if (bend !== 14'h0000) begin errors++; $display("FAIL bend_min: got %h want %h", bend, 14'h0000); end
    checks++; if (note !== 7'h43) begin errors++; $display("FAIL bend_note: got %h want %h", note, 7'h43); end
  endtask

  task automatic test_realtime();
    int s0;
    s0 = strobe_cnt;
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h45); send_byte(8'hFE); send_byte(8'h30);
    settle();
    checks++; if (note !== 7'h45) begin errors++; $display("FAIL rt_note: got %h want %h", note, 7'h45); end
    checks++; if (velocity !== 7'h30) begin errors++; $display("FAIL rt_vel: got %h want %h", velocity, 7'h30); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL rt_strobes: got %0d want 1", strobe_cnt - s0); end
    send_byte(8'h47); send_byte(8'h20);
    settle();
    checks++; if (note !== 7'h47) begin errors++; $display("FAIL rt_rs_note: got %h want %h", note, 7'h47); end
    checks++; if (velocity !== 7'h20) begin errors++; $display("FAIL rt_rs_vel: got %h want %h", velocity, 7'h20); end
  endtask

  task automatic test_filter();
    int s0;
    s0 = strobe_cnt;
    send_byte(8'h91); send_byte(8'h50); send_byte(8'h40);
    send_byte(8'h52); send_byte(8'h41);
    send_byte(8'h90); send_byte(8'hF0); send_byte(8'h22); send_byte(8'h33);
    settle();
    checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL filt_strobes: got %0d want 0", strobe_cnt - s0); end
    checks++; if (note !== 7'h47) begin errors++; $display("FAIL filt_note: got %h want %h", note, 7'h47); end
    checks++; if (velocity !== 7'h20) begin errors++; $display("FAIL filt_vel: got %h want %h", velocity, 7'h20); end
    checks++; if (gate !== 1'b1) begin errors++; $display("FAIL filt_gate: got %b want 1", gate); end
    send_byte(8'h80); send_byte(8'h47); send_byte(8'h00);
    settle();
    checks++; if (gate !== 1'b0) begin errors++; $display("FAIL noteoff_gate: got %b want 0", gate); end
  endtask

  task automatic test_errors();
    int f0, v0, s0;
    f0 = ferr_cnt;
    v0 = valid_cnt;
    send_frame(8'h47, 1'b0);
    repeat (DIV) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_bytes: got %0d want 0", valid_cnt - v0); end
    checks++; if (note !== 7'h47 || gate !== 1'b0 || bend !== 14'h0000) begin
      errors++; $display("FAIL ferr_outputs: got note %h gate %b bend %h want 47 0 0000", note, gate, bend);
    end
    // Low pulse well under half a bit
    f0 = ferr_cnt;
    v0 = valid_cnt;
    midi_in = 1'b0;
    repeat (DIV * 20 / 64) @(negedge clk);
    midi_in = 1'b1;
    repeat (DIV * 12) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_bytes: got %0d want 0", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
    s0 = strobe_cnt;
    send_byte(8'h90); send_byte(8'h30); send_byte(8'h10);
    settle();
    checks++; if (note !== 7'h30 || gate !== 1'b1) begin
      errors++; $display("FAIL recover: got note %h gate %b want 30 1", note, gate);
    end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL recover_strobes: got %0d want 1", strobe_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_running_status();
    test_pitch_bend();
    test_realtime();
    test_filter();
    test_errors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
